cache_mem_ctrl: RTL and testbench

Backing-memory controller that sits directly downstream of `cache_top` and serves its line refills and line write-backs. It holds the main-memory array, which is preloaded with a fixed address pattern. Each request runs through a fixed access latency and then a one-beat-per-cycle burst of a whole cache line. This gives the cache a deterministic, cycle-exact memory for miss and write-back testing.

---
 rtl/cache_mem_ctrl.sv | 144 ++++++++++++++
 tb/tb_cache_mem_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cache_mem_ctrl.sv
// Backing-memory controller for cache line refills and write-backs.
// Fixed access latency followed by a one-beat-per-cycle burst of a full line.
module cache_mem_ctrl #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_req,
  input  logic                          mem_we,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [31:0]                   mem_wdata,
  output logic                          mem_ack,
  output logic                          mem_busy,
  output logic                          mem_wready,
  output logic                          mem_rvalid,
  output logic [31:0]                   mem_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] mem_rbeat,
  output logic                          mem_done
);

  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = BEAT_W + 2;
  localparam int unsigned LINE_W = ADDR_W - OFF_W;
  localparam int unsigned WIDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH  = 1 << WIDX_W;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAT, S_XFER, S_DONE} state_e;
  typedef logic [31:0] mem_t [DEPTH];

  // Power-up image: word at byte address A holds 0x1000_0000 | (A >> 5).
  function automatic mem_t mem_pattern();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m[i] = 32'h1000_0000 | ((i << 2) >> 5);
    end
    return m;
  endfunction

  mem_t mem_q = mem_pattern();

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                we_q, we_d;

  logic                ack_d, busy_d, wready_d, rvalid_d, done_d;
  logic [31:0]         rdata_d;
  logic [BEAT_W-1:0]   rbeat_d;
  logic                xfer_d;

  logic                addr_unused;
  assign addr_unused = ^mem_addr[OFF_W-1:0];

  // State and output registers; storage is deliberately outside the reset domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      line_q     <= '0;
      we_q       <= 1'b0;
      mem_ack    <= 1'b0;
      mem_busy   <= 1'b0;
      mem_wready <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      mem_rbeat  <= '0;
      mem_done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      we_q       <= we_d;
      mem_ack    <= ack_d;
      mem_busy   <= busy_d;
      mem_wready <= wready_d;
      mem_rvalid <= rvalid_d;
      mem_rdata  <= rdata_d;
      mem_rbeat  <= rbeat_d;
      mem_done   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_XFER && we_q) begin
      mem_q[{line_q, beat_q}] <= mem_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    line_d  = line_q;
    we_d    = we_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          line_d  = mem_addr[ADDR_W-1:OFF_W];
          we_d    = mem_we;
          cnt_d   = CNT_W'(LATENCY - 1);
          beat_d  = '0;
          state_d = S_LAT;
        end
      end
      S_LAT: begin
        if (cnt_q == '0) begin
          beat_d  = '0;
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_XFER: begin
        if (beat_q == LAST_BEAT) begin
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight off a flop.
  always_comb begin
    xfer_d   = (state_d == S_XFER);
    ack_d    = (state_q == S_IDLE) && mem_req;
    busy_d   = (state_d != S_IDLE);
    rvalid_d = xfer_d && !we_d;
    wready_d = xfer_d && we_d;
    done_d   = (state_d == S_DONE);
    rbeat_d  = xfer_d ? beat_d : '0;
    rdata_d  = rvalid_d ? mem_q[{line_d, beat_d}] : mem_rdata;
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl: refills, write-backs, back-to-back requests, reset abort.
module tb_cache_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_busy;
  logic        mem_wready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rbeat;
  logic        mem_done;

  cache_mem_ctrl #(
    .ADDR_W    (16),
    .LINE_WORDS(4),
    .LATENCY   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_busy  (mem_busy),
    .mem_wready(mem_wready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .mem_rbeat (mem_rbeat),
    .mem_done  (mem_done)
  );

  typedef struct packed {
    logic [1:0]  beat;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic logic [38:0] all_outs();
    return {mem_ack, mem_busy, mem_wready, mem_rvalid, mem_done, mem_rdata, mem_rbeat};
  endfunction

  // Monitor: every read beat the DUT presents is matched against the queue.
  always @(negedge clk) begin
    if (!rst && mem_rvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rbeat", 64'(mem_rbeat), 64'(mon_e.beat));
        check("rdata", 64'(mem_rdata), 64'(mon_e.data));
      end
    end
  end

  // One request; d0..d3 are write beats or expected read beats. abort_k>0 pulses rst in that cycle.
  task automatic xfer(input logic [15:0] addr, input logic we,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] d3,
                      input int abort_k);
    logic [31:0] d [4];
    logic [4:0]  expv;
    d = '{d0, d1, d2, d3};
    if (!we) begin
      for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), d[i]});
    end
    @(negedge clk);
    mem_req  = 1'b1;
    mem_we   = we;
    mem_addr = addr;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mem_req  = 1'b0;
        mem_we   = ~we;
        mem_addr = 16'($urandom);
      end
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        check("abort_reset_outputs", 64'(all_outs()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      expv = {k == 1, k <= 9, we && k >= 5 && k <= 8, !we && k >= 5 && k <= 8, k == 9};
      check($sformatf("timing_c%0d", k),
            64'({mem_ack, mem_busy, mem_wready, mem_rvalid, mem_done}), 64'(expv));
      if (k >= 5 && k <= 8) check("beat_index", 64'(mem_rbeat), 64'(k - 5));
      mem_wdata = (we && k >= 5 && k <= 8) ? d[k-5] : $urandom;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(all_outs()), 64'd0);
    rst = 1'b0;

    xfer(16'h0000, 1'b0, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 0);
    xfer(16'h0404, 1'b0, 32'h1000_0020, 32'h1000_0020, 32'h1000_0020, 32'h1000_0020, 0);
    xfer(16'h0400, 1'b1, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0);
    xfer(16'h0400, 1'b0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0);
    xfer(16'h0410, 1'b0, 32'h1000_0020, 32'h1000_0020, 32'h1000_0020, 32'h1000_0020, 0);

    // Request held high: second accept lands in the first IDLE cycle.
    for (int i = 0; i < 8; i++) exp_q.push_back({2'(i % 4), 32'h1000_0040});
    @(negedge clk);
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 16'h0800;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 20) mem_req = 1'b0;
      check($sformatf("held_ack_rvalid_c%0d", k), 64'({mem_ack, mem_rvalid}),
            64'({k == 1 || k == 11, (k >= 5 && k <= 8) || (k >= 15 && k <= 18)}));
    end

    xfer(16'h0C00, 1'b1, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 7);
    xfer(16'h0C00, 1'b0, 32'hB0, 32'hB1, 32'h1000_0060, 32'h1000_0060, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
